// File: rtl/cache_memory_bridge_pkg.sv
// Shared command encodings, FSM state type and a width helper for the
// cache/memory bridge.
package cache_memory_bridge_pkg;

  localparam logic [1:0] CACHE_ILLEGAL_COMMAND        = 2'b00;
  localparam logic [1:0] CACHE_REQUEST_READIN_BLOCK   = 2'b01;
  localparam logic [1:0] CACHE_REQUEST_WRITEOUT_BLOCK = 2'b10;
  localparam logic [1:0] CACHE_SERVICE_READIN_BLOCK   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESPOND = 3'd4
  } bridge_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_memory_bridge.sv
// Drains the cache controller's command buffer one command at a time: block
// read-ins are fetched word by word and returned as a service response, dirty
// block write-outs are serialised to the word-wide memory port.
module cache_memory_bridge
  import cache_memory_bridge_pkg::*;
#(
  parameter int BW_ACCESS_ADDR    = 32,
  parameter int BW_DATA_WORD      = 32,
  parameter int N_WORDS_PER_BLOCK = 4,
  parameter int BW_CACHE_COMMAND  = 2
) (
  input  logic                                      clock_i,
  input  logic                                      reset_i,
  output logic                                      buffer_read_o,
  input  logic                                      buffer_empty_i,
  input  logic [BW_CACHE_COMMAND-1:0]               buffer_command_i,
  input  logic [BW_ACCESS_ADDR-1:0]                 buffer_address_i,
  input  logic [N_WORDS_PER_BLOCK*BW_DATA_WORD-1:0] buffer_data_i,
  output logic                                      buffer_write_o,
  input  logic                                      buffer_full_i,
  output logic [BW_CACHE_COMMAND-1:0]               buffer_command_o,
  output logic [BW_ACCESS_ADDR-1:0]                 buffer_address_o,
  output logic [N_WORDS_PER_BLOCK*BW_DATA_WORD-1:0] buffer_data_o,
  output logic                                      mem_request_o,
  output logic                                      mem_wren_o,
  output logic [BW_ACCESS_ADDR-1:0]                 mem_addr_o,
  output logic [BW_DATA_WORD-1:0]                   mem_data_o,
  input  logic                                      mem_ready_i,
  input  logic                                      mem_valid_i,
  input  logic [BW_DATA_WORD-1:0]                   mem_data_i,
  output logic                                      error_o
);

  localparam int BW_WORDS_PER_BLOCK = clog2(N_WORDS_PER_BLOCK);
  localparam int BW_DATA_BLOCK      = N_WORDS_PER_BLOCK * BW_DATA_WORD;
  localparam logic [BW_WORDS_PER_BLOCK-1:0] LAST_WORD = BW_WORDS_PER_BLOCK'(N_WORDS_PER_BLOCK - 1);

  bridge_state_e                 state_q, state_d;
  logic [BW_ACCESS_ADDR-1:0]     base_q, base_d;
  logic [BW_WORDS_PER_BLOCK-1:0] count_q, count_d;
  logic [BW_DATA_BLOCK-1:0]      block_q, block_d;
  logic                          error_q, error_d;
  logic [BW_CACHE_COMMAND-1:0]   resp_cmd_q, resp_cmd_d;
  logic [BW_ACCESS_ADDR-1:0]     resp_addr_q, resp_addr_d;
  logic [BW_DATA_BLOCK-1:0]      resp_data_q, resp_data_d;

  logic [BW_DATA_WORD-1:0]       block_words [N_WORDS_PER_BLOCK];
  logic [BW_DATA_BLOCK-1:0]      fill_block;
  logic [BW_ACCESS_ADDR-1:0]     head_base;
  logic [BW_ACCESS_ADDR-1:0]     word_addr;
  logic                          last_word;
  logic                          unused_offset_bits;

  // The offset bits of the incoming address never reach the memory side.
  assign head_base          = {buffer_address_i[BW_ACCESS_ADDR-1:BW_WORDS_PER_BLOCK],
                               {BW_WORDS_PER_BLOCK{1'b0}}};
  assign unused_offset_bits = ^buffer_address_i[BW_WORDS_PER_BLOCK-1:0];
  assign word_addr          = base_q | BW_ACCESS_ADDR'(count_q);
  assign last_word          = (count_q == LAST_WORD);

  for (genvar gi = 0; gi < N_WORDS_PER_BLOCK; gi++) begin : g_words
    assign block_words[gi] = block_q[gi*BW_DATA_WORD +: BW_DATA_WORD];
    assign fill_block[gi*BW_DATA_WORD +: BW_DATA_WORD] =
      (count_q == BW_WORDS_PER_BLOCK'(gi)) ? mem_data_i : block_q[gi*BW_DATA_WORD +: BW_DATA_WORD];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      block_q     <= '0;
      error_q     <= 1'b0;
      resp_cmd_q  <= '0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      block_q     <= block_d;
      error_q     <= error_d;
      resp_cmd_q  <= resp_cmd_d;
      resp_addr_q <= resp_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    block_d        = block_q;
    error_d        = error_q;
    resp_cmd_d     = resp_cmd_q;
    resp_addr_d    = resp_addr_q;
    resp_data_d    = resp_data_q;
    buffer_read_o  = 1'b0;
    buffer_write_o = 1'b0;
    mem_request_o  = 1'b0;
    mem_wren_o     = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    // Handshakes are suppressed while in reset so no command is popped and lost.
    if (!reset_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!buffer_empty_i) begin
            buffer_read_o = 1'b1;
            base_d        = head_base;
            block_d       = buffer_data_i;
            count_d       = '0;
            if (buffer_command_i == BW_CACHE_COMMAND'(CACHE_REQUEST_READIN_BLOCK)) begin
              state_d = ST_RD_REQ;
            end else if (buffer_command_i == BW_CACHE_COMMAND'(CACHE_REQUEST_WRITEOUT_BLOCK)) begin
              state_d = ST_WR_REQ;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ST_RD_REQ: begin
          mem_request_o = 1'b1;
          mem_addr_o    = word_addr;
          if (mem_ready_i) begin
            state_d = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_valid_i) begin
            block_d = fill_block;
            if (last_word) begin
              state_d = ST_RESPOND;
            end else begin
              count_d = count_q + 1'b1;
              state_d = ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          mem_request_o = 1'b1;
          mem_wren_o    = 1'b1;
          mem_addr_o    = word_addr;
          mem_data_o    = block_words[count_q];
          if (mem_ready_i) begin
            if (last_word) begin
              state_d = ST_IDLE;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          if (!buffer_full_i) begin
            buffer_write_o = 1'b1;
            resp_cmd_d     = BW_CACHE_COMMAND'(CACHE_SERVICE_READIN_BLOCK);
            resp_addr_d    = base_q;
            resp_data_d    = block_q;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Response fields show the live block while responding and hold it afterwards.
  assign buffer_command_o = (state_q == ST_RESPOND && !reset_i)
                            ? BW_CACHE_COMMAND'(CACHE_SERVICE_READIN_BLOCK) : resp_cmd_q;
  assign buffer_address_o = (state_q == ST_RESPOND && !reset_i) ? base_q  : resp_addr_q;
  assign buffer_data_o    = (state_q == ST_RESPOND && !reset_i) ? block_q : resp_data_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_cache_memory_bridge.sv
// Bench for cache_memory_bridge: directed scenarios followed by randomized
// traffic, scored against a transaction-level model of commands, memory and responses.
module tb_cache_memory_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int CW = 2;
  localparam int BW = NW * DW;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          buffer_read_o;
  logic          buffer_empty_i;
  logic [CW-1:0] buffer_command_i;
  logic [AW-1:0] buffer_address_i;
  logic [BW-1:0] buffer_data_i;
  logic          buffer_write_o;
  logic          buffer_full_i;
  logic [CW-1:0] buffer_command_o;
  logic [AW-1:0] buffer_address_o;
  logic [BW-1:0] buffer_data_o;
  logic          mem_request_o;
  logic          mem_wren_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ready_i;
  logic          mem_valid_i;
  logic [DW-1:0] mem_data_i;
  logic          error_o;

  cache_memory_bridge #(
    .BW_ACCESS_ADDR(AW), .BW_DATA_WORD(DW), .N_WORDS_PER_BLOCK(NW), .BW_CACHE_COMMAND(CW)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .buffer_read_o(buffer_read_o), .buffer_empty_i(buffer_empty_i),
    .buffer_command_i(buffer_command_i), .buffer_address_i(buffer_address_i),
    .buffer_data_i(buffer_data_i), .buffer_write_o(buffer_write_o),
    .buffer_full_i(buffer_full_i), .buffer_command_o(buffer_command_o),
    .buffer_address_o(buffer_address_o), .buffer_data_o(buffer_data_o),
    .mem_request_o(mem_request_o), .mem_wren_o(mem_wren_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
    .mem_data_i(mem_data_i), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [BW-1:0] data; } cmd_t;
  typedef struct { bit wren; logic [31:0] addr; logic [31:0] data; int resp_before; } mem_op_t;
  typedef struct { logic [31:0] addr; logic [BW-1:0] data; } resp_t;

  cmd_t    cmd_q[$];
  mem_op_t exp_ops[$];
  resp_t   exp_resp[$];

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, pushes = 0, pop_cyc = 0, push_cyc = 0, last_wr_cyc = 0;
  int n_readin_enq = 0, resp_seen = 0;
  bit exp_err = 0;
  bit rd_pending = 0;
  int rd_wait = 0;
  logic [31:0] rd_addr = '0;
  bit hold_valid = 0;
  logic        hold_wren;
  logic [31:0] hold_addr, hold_data;
  int ready_mode = 0, delay_min = 0, delay_max = 0;
  bit full_force = 0, full_rand = 0;
  int p0, q0, n;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input logic [1:0] cmd, input logic [31:0] addr, input logic [BW-1:0] data);
    cmd_t        c;
    resp_t       r;
    logic [31:0] base;
    base = {addr[31:2], 2'b00};
    c.cmd = cmd; c.addr = addr; c.data = data;
    cmd_q.push_back(c);
    if (cmd == 2'b01) begin
      r.addr = base;
      r.data = '0;
      for (int i = 0; i < NW; i++) begin
        exp_ops.push_back('{1'b0, base + i, mem_word(base + i), n_readin_enq});
        r.data[i*DW +: DW] = mem_word(base + i);
      end
      exp_resp.push_back(r);
      n_readin_enq++;
    end else if (cmd == 2'b10) begin
      for (int i = 0; i < NW; i++)
        exp_ops.push_back('{1'b1, base + i, data[i*DW +: DW], n_readin_enq});
    end
  endtask

  task automatic tick(input bit do_reset);
    bit      deliver;
    cmd_t    c;
    mem_op_t op;
    resp_t   r;
    deliver = 0;
    reset_i = do_reset;
    buffer_empty_i = (cmd_q.size() == 0);
    if (cmd_q.size() != 0) begin
      buffer_command_i = cmd_q[0].cmd;
      buffer_address_i = cmd_q[0].addr;
      buffer_data_i    = cmd_q[0].data;
    end else begin
      buffer_command_i = 2'($urandom);
      buffer_address_i = $urandom;
      buffer_data_i    = {$urandom, $urandom, $urandom, $urandom};
    end
    buffer_full_i = full_force || (full_rand && $urandom_range(0, 2) == 0);
    case (ready_mode)
      0:       mem_ready_i = 1'b1;
      1:       mem_ready_i = ~mem_ready_i;
      default: mem_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (rd_pending && rd_wait == 0) begin
      deliver     = 1;
      mem_valid_i = 1'b1;
      mem_data_i  = mem_word(rd_addr);
    end else begin
      if (rd_pending) rd_wait--;
      mem_valid_i = !rd_pending && ($urandom_range(0, 3) == 0);
      mem_data_i  = $urandom;
    end
    #1;
    check("error_o", error_o, exp_err);
    if (do_reset) begin
      hold_valid = 0;
      exp_ops.delete();
      exp_resp.delete();
      n_readin_enq = resp_seen;
      exp_err = 0;
    end else begin
      if (buffer_read_o) begin
        check("pop_when_empty", buffer_empty_i, 1'b0);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          if (c.cmd != 2'b01 && c.cmd != 2'b10) exp_err = 1;
        end
        pops++;
        pop_cyc = cyc;
      end
      if (hold_valid) begin
        check("hold_req", mem_request_o, 1'b1);
        check("hold_wren", mem_wren_o, hold_wren);
        check("hold_addr", mem_addr_o, hold_addr);
        check("hold_data", mem_data_o, hold_data);
      end
      if (mem_request_o) begin
        check("one_outstanding", rd_pending, 1'b0);
        if (mem_ready_i) begin
          hold_valid = 0;
          check("mem_op_expected", exp_ops.size() != 0, 1'b1);
          if (exp_ops.size() != 0) begin
            op = exp_ops.pop_front();
            check("mem_wren", mem_wren_o, op.wren);
            check("mem_addr", mem_addr_o, op.addr);
            if (op.wren) begin
              check("mem_wdata", mem_data_o, op.data);
              check("resp_before_write", resp_seen >= op.resp_before, 1'b1);
              last_wr_cyc = cyc;
            end else begin
              rd_pending = 1;
              rd_addr    = mem_addr_o;
              rd_wait    = $urandom_range(delay_max, delay_min);
            end
          end
        end else begin
          hold_valid = 1;
          hold_wren  = mem_wren_o;
          hold_addr  = mem_addr_o;
          hold_data  = mem_data_o;
        end
      end else begin
        hold_valid = 0;
      end
      if (buffer_write_o) begin
        check("push_while_full", buffer_full_i, 1'b0);
        check("push_expected", exp_resp.size() != 0, 1'b1);
        if (exp_resp.size() != 0) begin
          r = exp_resp.pop_front();
          check("resp_cmd", buffer_command_o, 2'b11);
          check("resp_addr", buffer_address_o, r.addr);
          check("resp_data", buffer_data_o, r.data);
        end
        resp_seen++;
        pushes++;
        push_cyc = cyc;
      end
    end
    if (deliver) rd_pending = 0;
    @(posedge clock_i);
    cyc++;
    @(negedge clock_i);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((cmd_q.size() != 0 || exp_ops.size() != 0 || exp_resp.size() != 0 || rd_pending) && k < budget) begin
      tick(0);
      k++;
    end
    check(tag, k < budget, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"}, buffer_read_o, 1'b0);
    check({tag, "_write"}, buffer_write_o, 1'b0);
    check({tag, "_rcmd"}, buffer_command_o, 2'b00);
    check({tag, "_raddr"}, buffer_address_o, 32'h0);
    check({tag, "_rdata"}, buffer_data_o, '0);
    check({tag, "_req"}, mem_request_o, 1'b0);
    check({tag, "_wren"}, mem_wren_o, 1'b0);
    check({tag, "_maddr"}, mem_addr_o, 32'h0);
    check({tag, "_mdata"}, mem_data_o, 32'h0);
    check({tag, "_err"}, error_o, 1'b0);
  endtask

  initial begin
    reset_i = 1'b1; buffer_empty_i = 1'b1; buffer_command_i = '0; buffer_address_i = '0;
    buffer_data_i = '0; buffer_full_i = 1'b0; mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    repeat (3) @(negedge clock_i);
    #1;
    check_all_zero("reset");

    // Zero-wait READIN: push lands 2N+1 cycles after the pop.
    ready_mode = 0; delay_min = 0; delay_max = 0;
    enqueue(2'b01, 32'h0000_1237, '0);
    p0 = pushes;
    drain("readin_drain", 200);
    check("readin_pushes", pushes - p0, 1);
    check("readin_latency", push_cyc - pop_cyc, 9);
    tick(0); tick(0);
    check("resp_hold_addr", buffer_address_o, 32'h0000_1234);
    check("resp_hold_data", buffer_data_o, {32'hA500_1237, 32'hA500_1236, 32'hA500_1235, 32'hA500_1234});
    check("resp_hold_cmd", buffer_command_o, 2'b11);

    // WRITEOUT with toggling ready, then zero-wait WRITEOUT latency.
    ready_mode = 1;
    p0 = pushes;
    enqueue(2'b10, 32'h40, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
    drain("write_toggle_drain", 200);
    check("write_no_push", pushes - p0, 0);
    ready_mode = 0;
    enqueue(2'b10, 32'h0000_0ABC, {$urandom, $urandom, $urandom, $urandom});
    drain("write_fast_drain", 200);
    check("write_latency", last_wr_cyc - pop_cyc, 4);

    // Response buffer full after the last word: no push until it drains.
    full_force = 1; ready_mode = 2; delay_max = 2;
    p0 = pushes;
    enqueue(2'b01, 32'h0000_0302, '0);
    n = 0;
    while ((exp_ops.size() != 0 || rd_pending) && n < 200) begin tick(0); n++; end
    check("full_reads_done", n < 200, 1'b1);
    repeat (5) tick(0);
    check("full_no_push", pushes - p0, 0);
    full_force = 0;
    drain("full_drain", 200);
    check("full_one_push", pushes - p0, 1);

    // Queued READIN then WRITEOUT are served in order.
    p0 = pushes; q0 = pops;
    enqueue(2'b01, 32'h100, '0);
    enqueue(2'b10, 32'h200, {$urandom, $urandom, $urandom, $urandom});
    drain("queued_drain", 400);
    check("queued_pops", pops - q0, 2);
    check("queued_pushes", pushes - p0, 1);

    // Illegal command sets the sticky error; the next READIN is still served.
    p0 = pushes;
    enqueue(2'b00, 32'h0000_7777, '0);
    enqueue(2'b01, 32'h80, '0);
    drain("illegal_drain", 300);
    check("illegal_err", error_o, 1'b1);
    check("illegal_then_push", pushes - p0, 1);

    // Reset while waiting for word 1's read data.
    ready_mode = 0; delay_min = 3; delay_max = 3;
    p0 = pushes;
    enqueue(2'b01, 32'h500, '0);
    n = 0;
    while (!(rd_pending && exp_ops.size() == 2) && n < 100) begin tick(0); n++; end
    check("reset_point_reached", n < 100, 1'b1);
    tick(1);
    reset_i = 1'b0; buffer_empty_i = 1'b1; mem_ready_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    check_all_zero("post_reset");
    repeat (8) tick(0);
    check("post_reset_no_push", pushes - p0, 0);
    drain("post_reset_drain", 50);

    // Randomized traffic.
    ready_mode = 2; full_rand = 1; delay_min = 0; delay_max = 3;
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [1:0] c;
      sel = $urandom_range(0, 19);
      c = (sel < 9) ? 2'b01 : (sel < 17) ? 2'b10 : (sel < 19) ? 2'b00 : 2'b11;
      enqueue(c, $urandom, {$urandom, $urandom, $urandom, $urandom});
    end
    drain("random_drain", 6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
